// File: rtl/ram_pkg.sv
// Shared types for the initialised single-port RAM: read-during-write
// behaviour selector and clear-engine state encoding.
package ram_pkg;

   // What a read returns when a write hits the same word in the same cycle.
   typedef enum logic [1:0] {
      RDW_READ_FIRST  = 2'd0,
      RDW_WRITE_FIRST = 2'd1,
      RDW_NO_CHANGE   = 2'd2
   } rdw_mode_t;

   // Clear engine: CLEAR walks the array writing the fill value, READY serves accesses.
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } ram_init_state_t;

   // Largest supported read latency (array register plus two delay stages).
   localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/ram_lat_pipe.sv
// Valid/data delay line placed after the array read register. Each data
// register loads only when the valid entering it is set, so the output
// data holds its last value between read results. STAGES = 0 is a wire.
module ram_lat_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   generate
      if (STAGES == 0) begin : g_pass
         // Clock and reset are not needed without delay stages.
         logic unused_ok_s;
         assign unused_ok_s = clk ^ rst;
         assign out_valid   = in_valid;
         assign out_data    = in_data;
      end else begin : g_stages
         logic [STAGES-1:0] vld_r;
         logic [WIDTH-1:0]  data_r [STAGES];

         // Shift valids every cycle; move data only along with a valid.
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_r <= '0;
               for (int s = 0; s < STAGES; s++) begin
                  data_r[s] <= '0;
               end
            end else begin
               vld_r[0] <= in_valid;
               if (in_valid) begin
                  data_r[0] <= in_data;
               end
               for (int s = 1; s < STAGES; s++) begin
                  vld_r[s] <= vld_r[s-1];
                  if (vld_r[s-1]) begin
                     data_r[s] <= data_r[s-1];
                  end
               end
            end
         end

         assign out_valid = vld_r[STAGES-1];
         assign out_data  = data_r[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/ram_sp_init_chk.sv
// Elaboration-time parameter legality checks for ram_sp_init.
module ram_sp_init_chk #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 256,
   parameter int BYTE_W = 8,
   parameter int RD_LAT = 1
) ();

   generate
      if (WIDTH % BYTE_W != 0) begin : g_bad_width
         $error("ram_sp_init: WIDTH must be a multiple of BYTE_W");
      end
      if (RD_LAT < 1 || RD_LAT > ram_pkg::RD_LAT_MAX) begin : g_bad_lat
         $error("ram_sp_init: RD_LAT must be in 1..3");
      end
      if (DEPTH < 2) begin : g_bad_depth
         $error("ram_sp_init: DEPTH must be at least 2");
      end
   endgenerate

endmodule

// File: rtl/ram_sp_init.sv
// Single-port synchronous RAM with byte-lane writes, configurable read
// latency, selectable read-during-write behaviour and a clear engine that
// fills the array with INIT_VAL after reset or on an init_i request.
module ram_sp_init
   import ram_pkg::*;
#(
   parameter int              WIDTH    = 32,
   parameter int              DEPTH    = 256,
   parameter int              BYTE_W   = 8,
   parameter int              RD_LAT   = 1,
   parameter rdw_mode_t       RDW_MODE = RDW_READ_FIRST,
   parameter bit              INIT_EN  = 1'b1,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      init_i,
   output logic                      ready_o,
   input  logic                      wr_en_i,
   input  logic [WIDTH/BYTE_W-1:0]   wr_byte_en_i,
   input  logic [$clog2(DEPTH)-1:0]  rw_addr_i,
   input  logic [WIDTH-1:0]          rw_data_i,
   input  logic                      rd_en_i,
   output logic [WIDTH-1:0]          rd_data_o,
   output logic                      rd_valid_o
);

   localparam int             LANES     = WIDTH / BYTE_W;
   localparam int             AW        = $clog2(DEPTH);
   localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
   localparam ram_init_state_t RST_STATE = INIT_EN ? ST_CLEAR : ST_READY;

   ram_sp_init_chk #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .BYTE_W (BYTE_W),
      .RD_LAT (RD_LAT)
   ) u_chk ();

   logic [WIDTH-1:0] mem [DEPTH];

   ram_init_state_t state_r;
   ram_init_state_t state_s;
   logic [AW-1:0]   cnt_r;
   logic [AW-1:0]   cnt_s;
   logic            ready_r;
   logic            clr_we_s;

   logic             wr_take_s;
   logic             rd_take_s;
   logic [WIDTH-1:0] old_word_s;
   logic [WIDTH-1:0] merged_word_s;
   logic [WIDTH-1:0] rd_word_s;

   logic             arr_valid_r;
   logic [WIDTH-1:0] arr_data_r;

   // Clear-engine next state: walk every address once, then serve accesses
   // until an init request restarts the walk from address 0.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      clr_we_s = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            clr_we_s = 1'b1;
            if (cnt_r == LAST_ADDR) begin
               state_s = ST_READY;
               cnt_s   = '0;
            end else begin
               cnt_s = cnt_r + AW'(1);
            end
         end
         ST_READY: begin
            if (init_i) begin
               state_s = ST_CLEAR;
               cnt_s   = '0;
            end else begin
               state_s = ST_READY;
            end
         end
         default: begin
            state_s = RST_STATE;
            cnt_s   = '0;
         end
      endcase
   end

   // Clear-engine state, counter and registered ready flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= RST_STATE;
         cnt_r   <= '0;
         ready_r <= !INIT_EN;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         ready_r <= (state_s == ST_READY);
      end
   end

   assign ready_o = ready_r;

   // Access qualification, lane merge and read-during-write word selection.
   always_comb begin
      wr_take_s     = ready_r & wr_en_i;
      rd_take_s     = ready_r & rd_en_i;
      old_word_s    = mem[rw_addr_i];
      merged_word_s = old_word_s;
      for (int l = 0; l < LANES; l++) begin
         if (wr_en_i && wr_byte_en_i[l]) begin
            merged_word_s[l*BYTE_W +: BYTE_W] = rw_data_i[l*BYTE_W +: BYTE_W];
         end else begin
            merged_word_s[l*BYTE_W +: BYTE_W] = old_word_s[l*BYTE_W +: BYTE_W];
         end
      end
      case (RDW_MODE)
         RDW_WRITE_FIRST: begin
            rd_word_s = merged_word_s;
         end
         RDW_NO_CHANGE: begin
            rd_word_s = old_word_s;
            if (wr_en_i) begin
               rd_take_s = 1'b0;
            end else begin
               rd_take_s = ready_r & rd_en_i;
            end
         end
         default: begin
            rd_word_s = old_word_s;
         end
      endcase
   end

   // Array write port: fill value while clearing, merged word on accepted writes.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (clr_we_s) begin
            mem[cnt_r] <= INIT_VAL;
         end else if (wr_take_s && (|wr_byte_en_i)) begin
            mem[rw_addr_i] <= merged_word_s;
         end
      end
   end

   // Array read register: captures the selected word on an accepted read.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         arr_valid_r <= 1'b0;
         arr_data_r  <= '0;
      end else begin
         arr_valid_r <= rd_take_s;
         if (rd_take_s) begin
            arr_data_r <= rd_word_s;
         end
      end
   end

   ram_lat_pipe #(
      .WIDTH  (WIDTH),
      .STAGES (RD_LAT - 1)
   ) u_pipe (
      .clk       (clk_i),
      .rst       (rst_i),
      .in_valid  (arr_valid_r),
      .in_data   (arr_data_r),
      .out_valid (rd_valid_o),
      .out_data  (rd_data_o)
   );

endmodule
